// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the FIFO pointer controller.
package fifo_pkg;
  localparam int FIFO_N     = 4;
  localparam int FIFO_DEPTH = 1 << FIFO_N;
  localparam int FIFO_PW    = FIFO_N + 1;

  function automatic int depth_of(input int n);
    return 1 << n;
  endfunction

  // pointer width: address bits plus one wrap bit
  function automatic int ptr_w(input int n);
    return n + 1;
  endfunction
endpackage

// File: rtl/fifo_ctrl_if.sv
// Producer/consumer handshake and RAM sequencing bundle for fifo_ctrl.
// AlmostFull/AlmostEmpty exist only when FIFO_ALMOST_EN is defined.
interface fifo_ctrl_if #(parameter int N = 4);
  logic         WrEn;
  logic         RdEn;
  logic         RamWe;
  logic [N-1:0] WrAddr;
  logic [N-1:0] RdAddr;
  logic         Full;
  logic         Empty;
  logic [N:0]   Count;
  logic [N:0]   WrPtrGray;
  logic [N:0]   RdPtrGray;
  logic         Overflow;
  logic         Underflow;
`ifdef FIFO_ALMOST_EN
  logic         AlmostFull;
  logic         AlmostEmpty;
`endif

  modport master (
    output WrEn, RdEn,
    input  RamWe, WrAddr, RdAddr, Full, Empty, Count,
           WrPtrGray, RdPtrGray, Overflow, Underflow
`ifdef FIFO_ALMOST_EN
    , input AlmostFull, AlmostEmpty
`endif
  );

  modport slave (
    input  WrEn, RdEn,
    output RamWe, WrAddr, RdAddr, Full, Empty, Count,
           WrPtrGray, RdPtrGray, Overflow, Underflow
`ifdef FIFO_ALMOST_EN
    , output AlmostFull, AlmostEmpty
`endif
  );
endinterface

// File: rtl/fifo_ctrl_bin2gray.sv
// Binary to reflected-Gray conversion, purely combinational.
module bin2gray #(parameter int W = 5) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);
  assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO pointer controller for an external 2^N-word dual-port RAM.
// Optional FIFO_ALMOST_EN adds registered AlmostFull/AlmostEmpty flags.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int N = FIFO_N
`ifdef FIFO_ALMOST_EN
  , parameter int AF_GAP = 1
  , parameter int AE_GAP = 1
`endif
) (
  input logic       clk,
  input logic       rst,
  fifo_ctrl_if.slave bus
);
  localparam int PW    = ptr_w(N);
  localparam int DEPTH = depth_of(N);

  logic [PW-1:0] wptr, rptr, wptr_n, rptr_n, cnt_n;
  logic [PW-1:0] wg_n, rg_n;
  logic [PW-1:0] cnt_q, wg_q, rg_q;
  logic          full_q, empty_q, ovf_q, udf_q;
  logic          wr_acc, rd_acc;
  logic          full_n, empty_n;

  // acceptance uses only the registered flags, so RamWe has no RdEn path
  assign wr_acc = bus.WrEn & ~full_q;
  assign rd_acc = bus.RdEn & ~empty_q;

  assign wptr_n  = wptr + PW'(wr_acc);
  assign rptr_n  = rptr + PW'(rd_acc);
  assign cnt_n   = wptr_n - rptr_n;
  assign empty_n = (wptr_n == rptr_n);
  assign full_n  = (wptr_n[N] != rptr_n[N]) & (wptr_n[N-1:0] == rptr_n[N-1:0]);

  bin2gray #(.W(PW)) u_wgray (.bin(wptr_n), .gray(wg_n));
  bin2gray #(.W(PW)) u_rgray (.bin(rptr_n), .gray(rg_n));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      cnt_q   <= '0;
      wg_q    <= '0;
      rg_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr    <= wptr_n;
      rptr    <= rptr_n;
      cnt_q   <= cnt_n;
      wg_q    <= wg_n;
      rg_q    <= rg_n;
      full_q  <= full_n;
      empty_q <= empty_n;
      ovf_q   <= bus.WrEn & full_q;
      udf_q   <= bus.RdEn & empty_q;
    end
  end

`ifdef FIFO_ALMOST_EN
  localparam logic [PW-1:0] AF_TH = PW'(DEPTH - AF_GAP);
  localparam logic [PW-1:0] AE_TH = PW'(AE_GAP);
  logic af_q, ae_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      af_q <= 1'b0;
      ae_q <= 1'b1;
    end else begin
      af_q <= (cnt_n >= AF_TH);
      ae_q <= (cnt_n <= AE_TH);
    end
  end

  assign bus.AlmostFull  = af_q;
  assign bus.AlmostEmpty = ae_q;
`endif

  assign bus.RamWe     = wr_acc;
  assign bus.WrAddr    = wptr[N-1:0];
  assign bus.RdAddr    = rptr[N-1:0];
  assign bus.Full      = full_q;
  assign bus.Empty     = empty_q;
  assign bus.Count     = cnt_q;
  assign bus.WrPtrGray = wg_q;
  assign bus.RdPtrGray = rg_q;
  assign bus.Overflow  = ovf_q;
  assign bus.Underflow = udf_q;
endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl at N=2 (DEPTH=4); expectations are hand-derived.
module tb_fifo_ctrl;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  // reflected Gray codes of 0..7
  logic [2:0] gtab [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                           3'b110, 3'b111, 3'b101, 3'b100};

  always #5 clk = ~clk;

  fifo_ctrl_if #(.N(N)) bus ();

  fifo_ctrl #(
    .N(N)
`ifdef FIFO_ALMOST_EN
    , .AF_GAP(1), .AE_GAP(1)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int mw, mr;
  logic [2:0] pwg, prg;

  initial begin
    bus.WrEn = 1'b0;
    bus.RdEn = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    #1;

    // reset state
    chk("rst_empty", bus.Empty, 1);
    chk("rst_full",  bus.Full, 0);
    chk("rst_count", bus.Count, 0);
    chk("rst_waddr", bus.WrAddr, 0);
    chk("rst_raddr", bus.RdAddr, 0);
    chk("rst_wgray", bus.WrPtrGray, 0);
    chk("rst_rgray", bus.RdPtrGray, 0);
    chk("rst_ovf",   bus.Overflow, 0);
    chk("rst_udf",   bus.Underflow, 0);
`ifdef FIFO_ALMOST_EN
    chk("rst_ae", bus.AlmostEmpty, 1);
    chk("rst_af", bus.AlmostFull, 0);
`endif

    // fill to full
    for (int i = 0; i < 4; i++) begin
      bus.WrEn = 1'b1;
      #1;
      chk("fill_we",   bus.RamWe, 1);
      chk("fill_addr", bus.WrAddr, i);
      tick();
      chk("fill_cnt",  bus.Count, i + 1);
      chk("fill_wg",   bus.WrPtrGray, gtab[i+1]);
`ifdef FIFO_ALMOST_EN
      chk("fill_af", bus.AlmostFull, (i + 1 >= 3) ? 1 : 0);
      chk("fill_ae", bus.AlmostEmpty, (i + 1 <= 1) ? 1 : 0);
`endif
    end
    chk("full_flag",  bus.Full, 1);
    chk("full_empty", bus.Empty, 0);
    chk("full_ovf0",  bus.Overflow, 0);

    // fifth write rejected
    #1;
    chk("ovf_we", bus.RamWe, 0);
    bus.RdEn = 1'b1;
    #1;
    chk("ovf_we_rd", bus.RamWe, 0);
    bus.RdEn = 1'b0;
    tick();
    chk("ovf_pulse", bus.Overflow, 1);
    chk("ovf_cnt",   bus.Count, 4);
    chk("ovf_wg",    bus.WrPtrGray, 3'b110);
    chk("ovf_waddr", bus.WrAddr, 0);
    bus.WrEn = 1'b0;
    tick();
    chk("ovf_clear", bus.Overflow, 0);
    chk("ovf_wg2",   bus.WrPtrGray, 3'b110);

    // full with both requests: read wins, write overflows
    bus.WrEn = 1'b1;
    bus.RdEn = 1'b1;
    tick();
    chk("fb_cnt",   bus.Count, 3);
    chk("fb_full",  bus.Full, 0);
    chk("fb_ovf",   bus.Overflow, 1);
    chk("fb_raddr", bus.RdAddr, 1);
    chk("fb_rg",    bus.RdPtrGray, 3'b001);
    bus.WrEn = 1'b0;

    // drain
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drain_cnt", bus.Count, 2 - i);
    end
    chk("drain_empty", bus.Empty, 1);
    chk("drain_udf",   bus.Underflow, 0);
    chk("drain_rg",    bus.RdPtrGray, 3'b110);

    // empty with both requests: write wins, read underflows
    bus.WrEn = 1'b1;
    tick();
    chk("eb_cnt",   bus.Count, 1);
    chk("eb_empty", bus.Empty, 0);
    chk("eb_udf",   bus.Underflow, 1);
    chk("eb_ovf",   bus.Overflow, 0);

    // streaming pairs; wptr 5->17, rptr 4->16: two wraps each
    mw = 5; mr = 4;
    pwg = bus.WrPtrGray; prg = bus.RdPtrGray;
    for (int i = 0; i < 12; i++) begin
      tick();
      mw = (mw + 1) % 8;
      mr = (mr + 1) % 8;
      chk("st_cnt",   bus.Count, 1);
      chk("st_full",  bus.Full, 0);
      chk("st_empty", bus.Empty, 0);
      chk("st_wg",    bus.WrPtrGray, gtab[mw]);
      chk("st_rg",    bus.RdPtrGray, gtab[mr]);
      chk("st_wstep", $countones(pwg ^ bus.WrPtrGray), 1);
      chk("st_rstep", $countones(prg ^ bus.RdPtrGray), 1);
      chk("st_waddr", bus.WrAddr, mw % 4);
      chk("st_raddr", bus.RdAddr, mr % 4);
      if (i == 0) chk("st_udf_clr", bus.Underflow, 0);
      pwg = bus.WrPtrGray; prg = bus.RdPtrGray;
    end
    bus.RdEn = 1'b0;

    // climb from 1 to 3 to cross the almost thresholds
    tick();
    chk("up_cnt2", bus.Count, 2);
`ifdef FIFO_ALMOST_EN
    chk("up_ae2", bus.AlmostEmpty, 0);
    chk("up_af2", bus.AlmostFull, 0);
`endif
    tick();
    chk("up_cnt3", bus.Count, 3);
    chk("up_full3", bus.Full, 0);
`ifdef FIFO_ALMOST_EN
    chk("up_af3", bus.AlmostFull, 1);
`endif
    bus.WrEn = 1'b0;

    // async reset mid-cycle
    #2;
    rst = 1'b1;
    #1;
    chk("ar_cnt",   bus.Count, 0);
    chk("ar_empty", bus.Empty, 1);
    chk("ar_waddr", bus.WrAddr, 0);
    chk("ar_wg",    bus.WrPtrGray, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("ar_post_cnt", bus.Count, 0);
    chk("ar_post_full", bus.Full, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
